seg_score_display: RTL and testbench
====================================

Name: seg_score_display

Overview:
- Parametrised multi-channel score counter with multiplexed 7-segment driver.
- Successor to the fixed 2-score, 4-digit display block; sits between game logic and the board's 7-segment pins.
- Holds N_CH independent BCD score counters, each DIG_PER_CH digits wide.
- Scans all digits time-multiplexed and signals a win via a one-cycle `rst_out` pulse.

Parameters:
- N_CH, 2, number of score channels.
- ADDR_W, 1, width of `addr`; N_CH <= 2**ADDR_W.
- DIG_PER_CH, 2, BCD digits per channel; NUM_DIG = N_CH*DIG_PER_CH.
- REFRESH_DIV, 100000, clk cycles each digit stays lit.
- WIN_SCORE, 15, decimal score that triggers a win; 0 disables win detection.

Ports:
- clk  in  1  system clock (100 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- sel  in  1  command strobe, one clk cycle wide
- addr  in  ADDR_W  channel select for the command
- data_in  in  1  command: 1 = increment, 0 = clear channel
- cathode  out  8  active-low segments, [6:0]=g..a, [7]=dp
- anode  out  NUM_DIG  active-low digit enables
- rst_out  out  1  one-cycle win pulse

Behaviour:
- Reset (async, rst=1):
  - all counters 0, scan index 0, refresh counter 0
  - anode = all ones, cathode = 8'hFF, rst_out = 0
- Commands:
  - Sampled on the rising edge where sel=1. Counter update is visible the following cycle (latency 1).
  - `addr` >= N_CH: command ignored.
  - Increment: BCD add 1 with digit carry. Wraps from 10^DIG_PER_CH-1 to 0; no other effect on wrap.
  - Clear: selected channel goes to 0; other channels unchanged.
- Win detection:
  - Applies when WIN_SCORE != 0 and an increment's next value equals WIN_SCORE.
  - The same edge that updates the counter also registers rst_out=1.
  - During that cycle (rst_out high) the winning count is visible. At the next edge, all channels clear to 0 and rst_out returns to 0.
  - A sel arriving in the rst_out-high cycle is dropped; clear has priority.
  - Two channels cannot win together (one command per cycle).
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances, wrapping NUM_DIG-1 -> 0.
  - Digit index i = c*DIG_PER_CH + d, where c = channel and d = digit position (0 = least significant).
  - anode = ~(1<<i), registered.
  - cathode = registered decode of digit i, dp always off (bit7=1).
  - Decode map: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any non-BCD value decodes to FF.
  - The first edge after reset release loads anode for index 0; the refresh counter starts at 0.
  - Counter updates appear on cathode at the next registered decode of that digit (≤1 extra cycle).
- Reset mid-operation: immediate return to reset values; no pending command or win survives.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: within each channel, a digit d>0 is blanked (cathode=FF, anode still driven) when it and every more significant digit of that channel are 0. Digit 0 always shows.
- Undefined: all digits always show, including leading zeros (e.g. 05 shows C0 on the tens digit).

Test Plan:
- Bench parameters: REFRESH_DIV=4, N_CH=2, DIG_PER_CH=2 unless stated.
- Reset: rst=1 for 5 cycles -> anode=4'hF, cathode=8'hFF, rst_out=0. Release -> anode sequence E,D,B,7 repeating, each held 4 cycles, cathode=C0 throughout.
- Increment channel 1: 13 strobes (sel=1, addr=1, data_in=1, 20 cycles apart) -> anode=B shows cathode=B0, anode=7 shows F9. Channel 0 digits stay C0; rst_out stays 0.
- Win: 15 increments on addr=0, WIN_SCORE=15 -> rst_out=1 exactly one cycle, starting the cycle after the 15th strobe. The following cycle both channels read 00 (all digits C0). A strobe issued in the rst_out-high cycle has no effect.
- Clear: ch0=7, ch1=3; strobe addr=1, data_in=0 -> ch1=00, ch0 still shows F8 on anode=E.
- Wrap and disabled win: WIN_SCORE=0, 100 increments on ch0 -> ch0=00, rst_out never asserted. Then rst=1 mid-scan (refresh count 2) -> anode=F immediately, and the scan restarts at anode=E after release.
- Optional feature: with SEG_LEADING_ZERO_BLANK_EN, ch0=05 -> anode=D shows cathode=FF, anode=E shows 92. Without the macro, anode=D shows C0.

Source files
------------

// File: rtl/seg_score_display.sv
// rtl/seg_score_display.sv - multi-channel BCD score counters with multiplexed 7-segment scan
//
// Holds N_CH independent BCD score counters of DIG_PER_CH digits each and scans
// all NUM_DIG = N_CH*DIG_PER_CH digits onto a common-cathode-bus display.
// An increment that lands exactly on WIN_SCORE raises rst_out for one cycle,
// after which every channel is cleared.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   sel      in   one-cycle command strobe
//   addr     in   [ADDR_W-1:0] channel select; values >= N_CH are ignored
//   data_in  in   1 = increment selected channel, 0 = clear it
//   cathode  out  [7:0] active-low segments, [6:0] = g..a, [7] = dp (always off)
//   anode    out  [NUM_DIG-1:0] active-low digit enables
//   rst_out  out  one-cycle win pulse
//
// Optional build macro: SEG_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (d > 0) of each channel are blanked.
module seg_score_display #(
   parameter int N_CH        = 2,
   parameter int ADDR_W      = 1,
   parameter int DIG_PER_CH  = 2,
   parameter int REFRESH_DIV = 100000,
   parameter int WIN_SCORE   = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sel,
   input  logic [ADDR_W-1:0]            addr,
   input  logic                         data_in,
   output logic [7:0]                   cathode,
   output logic [N_CH*DIG_PER_CH-1:0]   anode,
   output logic                         rst_out
);

   localparam int NUM_DIG = N_CH * DIG_PER_CH;
   localparam int CH_W    = DIG_PER_CH * 4;
   localparam int CNT_W   = NUM_DIG * 4;
   localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

   // Decimal-to-BCD conversion of the win threshold, done at elaboration.
   function automatic logic [CH_W-1:0] to_bcd(input int value);
      logic [CH_W-1:0] bcd;
      int              v;
      bcd = '0;
      v   = value;
      for (int d = 0; d < DIG_PER_CH; d++) begin
         bcd[d*4 +: 4] = 4'(v % 10);
         v             = v / 10;
      end
      return bcd;
   endfunction

   // A threshold that cannot be represented in DIG_PER_CH digits can never be
   // reached, so it disables detection instead of matching a truncated value.
   localparam bit              WIN_EN  = (WIN_SCORE > 0) && (WIN_SCORE < 10**DIG_PER_CH);
   localparam logic [CH_W-1:0] WIN_BCD = to_bcd(WIN_SCORE);
   localparam logic [NUM_DIG-1:0] ANODE_ONE = NUM_DIG'(1);

   // Ripple BCD increment; the all-nines value wraps to zero.
   function automatic logic [CH_W-1:0] bcd_inc(input logic [CH_W-1:0] v);
      logic [CH_W-1:0] r;
      logic            carry;
      r     = v;
      carry = 1'b1;
      for (int d = 0; d < DIG_PER_CH; d++) begin
         if (carry) begin
            if (r[d*4 +: 4] == 4'd9) begin
               r[d*4 +: 4] = 4'd0;
            end else begin
               r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg_decode(input logic [3:0] v);
      logic [7:0] s;
      case (v)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_DIG-1:0] anode_q, anode_d;
   logic [7:0]         cathode_q, cathode_d;
   logic               rst_out_q, rst_out_d;

   // Score counters and win detection.
   always_comb begin
      logic [CH_W-1:0] nxt;
      cnt_d     = cnt_q;
      rst_out_d = 1'b0;
      nxt       = '0;
      if (rst_out_q) begin
         // Win clear takes priority; a strobe in this cycle is dropped.
         cnt_d = '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (sel && (int'(addr) == c)) begin
               if (data_in) begin
                  nxt                     = bcd_inc(cnt_q[c*CH_W +: CH_W]);
                  cnt_d[c*CH_W +: CH_W]   = nxt;
                  if (WIN_EN && (nxt == WIN_BCD)) begin
                     rst_out_d = 1'b1;
                  end
               end else begin
                  cnt_d[c*CH_W +: CH_W] = '0;
               end
            end
         end
      end
   end

   // Refresh divider, scan index and registered digit drive.
   always_comb begin
      logic [3:0] digit;
      logic       blank;
      logic       hi_zero;
      ref_d   = ref_q;
      idx_d   = idx_q;
      digit   = 4'hF;
      blank   = 1'b0;
      hi_zero = 1'b1;

      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
         ref_d = ref_q + REF_W'(1);
      end

      for (int c = 0; c < N_CH; c++) begin
         for (int d = 0; d < DIG_PER_CH; d++) begin
            if (int'(idx_q) == c*DIG_PER_CH + d) begin
               digit = cnt_q[(c*DIG_PER_CH + d)*4 +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
               // Blank when this digit and every more significant digit of
               // the channel are zero; the units digit always shows.
               hi_zero = 1'b1;
               for (int k = d; k < DIG_PER_CH; k++) begin
                  if (cnt_q[(c*DIG_PER_CH + k)*4 +: 4] != 4'd0) begin
                     hi_zero = 1'b0;
                  end
               end
               blank = (d > 0) && hi_zero;
`else
               blank = 1'b0;
`endif
            end
         end
      end

      anode_d   = ~(ANODE_ONE << idx_q);
      cathode_d = blank ? 8'hFF : seg_decode(digit);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         ref_q     <= '0;
         idx_q     <= '0;
         anode_q   <= '1;
         cathode_q <= 8'hFF;
         rst_out_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         ref_q     <= ref_d;
         idx_q     <= idx_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
         rst_out_q <= rst_out_d;
      end
   end

   assign anode   = anode_q;
   assign cathode = cathode_q;
   assign rst_out = rst_out_q;

endmodule

// File: tb/tb_seg_score_display.sv
// tb/tb_seg_score_display.sv - scoreboard bench for seg_score_display (win-enabled and win-disabled instances)
`timescale 1ns/1ps
module tb_seg_score_display;

   localparam int REF = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sel = 1'b0;
   logic [1:0] addr = 2'd0;
   logic       data_in = 1'b0;

   wire [3:0] an0, an1;
   wire [7:0] ca0, ca1;
   wire       ro0, ro1;

   seg_score_display #(.N_CH(2), .ADDR_W(2), .DIG_PER_CH(2), .REFRESH_DIV(REF), .WIN_SCORE(15)) dut0 (
      .clk(clk), .rst(rst), .sel(sel), .addr(addr), .data_in(data_in),
      .cathode(ca0), .anode(an0), .rst_out(ro0)
   );

   seg_score_display #(.N_CH(2), .ADDR_W(2), .DIG_PER_CH(2), .REFRESH_DIV(REF), .WIN_SCORE(0)) dut1 (
      .clk(clk), .rst(rst), .sel(sel), .addr(addr), .data_in(data_in),
      .cathode(ca1), .anode(an1), .rst_out(ro1)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: decimal scores per instance and channel.
   int sc [2][2] = '{'{0, 0}, '{0, 0}};
   bit pend [2]  = '{1'b0, 1'b0};
   int win_cfg [2] = '{15, 0};
   int cyc = 0;
   int winq [2][$];

   logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            sc[k][0] = 0; sc[k][1] = 0; pend[k] = 1'b0;
         end else if (pend[k]) begin
            sc[k][0] = 0; sc[k][1] = 0; pend[k] = 1'b0;
         end else if (sel && addr < 2) begin
            if (data_in) begin
               sc[k][addr] = (sc[k][addr] + 1) % 100;
               if (win_cfg[k] != 0 && sc[k][addr] == win_cfg[k]) begin
                  pend[k] = 1'b1;
                  winq[k].push_back(cyc);
               end
            end else begin
               sc[k][addr] = 0;
            end
         end
      end
   end

   typedef struct {
      time             t;
      logic [3:0][7:0] c;
   } frame_t;

   frame_t fq [2][$];

   function automatic logic [3:0][7:0] exp_frame(input int k);
      logic [3:0][7:0] f;
      int v;
      logic [7:0] e;
      for (int c = 0; c < 2; c++) begin
         for (int d = 0; d < 2; d++) begin
            v = sc[k][c] / ((d == 0) ? 1 : 10);
            e = seg_tab[v % 10];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && v == 0) e = 8'hFF;
`endif
            f[c*2 + d] = e;
         end
      end
      return f;
   endfunction

   // Monitor: scan order/timing, win pulses, full-frame cathode compare.
   logic [3:0]      prev_an [2] = '{4'hF, 4'hF};
   int              run [2]     = '{0, 0};
   int              idx_prev [2] = '{0, 0};
   bit              got [2]     = '{1'b0, 1'b0};
   time             ts [2];
   logic [3:0][7:0] fr [2];
   frame_t          mon_e;

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [3:0] a;
         logic [7:0] c;
         logic       r;
         int         ix;
         int         wexp;
         a = (k == 0) ? an0 : an1;
         c = (k == 0) ? ca0 : ca1;
         r = (k == 0) ? ro0 : ro1;
         if (r) begin
            if (winq[k].size() == 0) begin
               chk($sformatf("dut%0d unexpected rst_out", k), 1, 0);
            end else begin
               wexp = winq[k].pop_front();
               chk($sformatf("dut%0d rst_out cycle", k), cyc, wexp);
            end
         end
         if (rst) begin
            prev_an[k] = 4'hF; got[k] = 1'b0; run[k] = 0;
         end else if (a == prev_an[k]) begin
            run[k]++;
         end else begin
            case (a)
               4'hE: ix = 0;
               4'hD: ix = 1;
               4'hB: ix = 2;
               4'h7: ix = 3;
               default: ix = -1;
            endcase
            chk($sformatf("dut%0d anode pattern %0h", k, a), (ix >= 0) ? 1 : 0, 1);
            if (prev_an[k] == 4'hF) begin
               chk($sformatf("dut%0d first digit after reset", k), ix, 0);
            end else begin
               chk($sformatf("dut%0d digit hold cycles", k), run[k], REF);
               chk($sformatf("dut%0d scan order", k), ix, (idx_prev[k] + 1) % 4);
            end
            prev_an[k] = a; run[k] = 1; idx_prev[k] = ix;
            if (ix == 0) begin
               got[k] = 1'b1; ts[k] = $time; fr[k][0] = c;
            end else if (ix > 0 && got[k]) begin
               fr[k][ix] = c;
               if (ix == 3) begin
                  got[k] = 1'b0;
                  if (fq[k].size() > 0 && ts[k] > fq[k][0].t + 5) begin
                     mon_e = fq[k].pop_front();
                     for (int i = 0; i < 4; i++)
                        chk($sformatf("dut%0d digit%0d cathode", k, i), fr[k][i], mon_e.c[i]);
                  end
               end
            end
         end
      end
   end

   task automatic push_exp();
      frame_t e;
      for (int k = 0; k < 2; k++) begin
         e.t = $time;
         e.c = exp_frame(k);
         fq[k].push_back(e);
      end
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (fq[0].size() == 0 && fq[1].size() == 0) break;
      end
      chk("frame queue drained", fq[0].size() + fq[1].size(), 0);
      fq[0].delete();
      fq[1].delete();
   endtask

   task automatic strobe(input logic [1:0] a, input logic d);
      @(posedge clk); #1;
      sel = 1'b1; addr = a; data_in = d;
      @(posedge clk); #1;
      sel = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset state
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset anode0", an0, 4'hF);
      chk("reset anode1", an1, 4'hF);
      chk("reset cathode0", ca0, 8'hFF);
      chk("reset cathode1", ca1, 8'hFF);
      chk("reset rst_out0", ro0, 0);
      chk("reset rst_out1", ro1, 0);
      rst = 1'b0;
      push_exp();

      // 13 increments on channel 1
      for (int i = 0; i < 13; i++) begin
         strobe(2'd1, 1'b1);
         push_exp();
      end

      // Win on channel 0; a strobe held into the rst_out-high cycle is dropped
      for (int i = 0; i < 14; i++) strobe(2'd0, 1'b1);
      @(posedge clk); #1;
      sel = 1'b1; addr = 2'd0; data_in = 1'b1;
      @(posedge clk); #1;
      addr = 2'd1;
      @(posedge clk); #1;
      sel = 1'b0;
      @(posedge clk); #1;
      push_exp();

      // Clear one channel, other unchanged
      strobe(2'd0, 1'b0);
      strobe(2'd1, 1'b0);
      for (int i = 0; i < 7; i++) strobe(2'd0, 1'b1);
      for (int i = 0; i < 3; i++) strobe(2'd1, 1'b1);
      push_exp();
      strobe(2'd1, 1'b0);
      push_exp();

      // Wrap: 100 increments
      strobe(2'd0, 1'b0);
      for (int i = 0; i < 100; i++) strobe(2'd0, 1'b1);
      push_exp();

      // Reset mid-scan at refresh count 2
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (an0 == 4'hD) break;
      end
      chk("mid-scan wait for anode D", an0, 4'hD);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid reset anode0", an0, 4'hF);
      chk("mid reset anode1", an1, 4'hF);
      chk("mid reset cathode0", ca0, 8'hFF);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      push_exp();

      // Leading-zero display with ch0 = 05, then ignored addresses
      for (int i = 0; i < 5; i++) strobe(2'd0, 1'b1);
      push_exp();
      strobe(2'd2, 1'b1);
      strobe(2'd3, 1'b0);
      push_exp();

      // Randomized commands
      for (int i = 0; i < 30; i++) begin
         strobe(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
         push_exp();
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("dut0 missing win pulses", winq[0].size(), 0);
      chk("dut1 missing win pulses", winq[1].size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
